mul_unit: RTL and testbench
===========================

MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit, request to begin a multiply with the current operands and mulctl.
REQ-005 SHALL have port mulctl, input, 2 bits, operation select: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-006 SHALL have port rs1, input, XLEN bits, multiplicand.
REQ-007 SHALL have port rs2, input, XLEN bits, multiplier.
REQ-008 SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-009 SHALL have port exdone, output, 1 bit, single-cycle completion pulse to the controller.
REQ-010 SHALL have port result, output, XLEN bits, product slice selected by mulctl.

Function
REQ-011 SHALL implement states IDLE, CALC and DONE.
REQ-012 IDLE: start=1 sampled -> latch rs1, rs2 and mulctl, clear count, go to CALC.
REQ-013 SHALL latch operands as sign-corrected magnitudes: rs1 signed for MULH and MULHSU; rs2 signed for MULH only.
REQ-014 CALC: one shift-add step per cycle over a 2*XLEN accumulator; after exactly XLEN steps, go to DONE.
REQ-015 DONE: negate the 2*XLEN product when the operand signs differ, drive result, assert exdone for exactly one cycle, return to IDLE.
REQ-016 result SHALL be low XLEN bits for MUL and high XLEN bits for MULH, MULHSU and MULHU.
REQ-017 Latency: exdone SHALL be high in the cycle that starts XLEN+1 edges after the edge that sampled start (33 for XLEN=32).
REQ-018 busy SHALL be high in CALC and DONE and low in IDLE.
REQ-019 start while busy SHALL be ignored: no relatch, no restart, no queuing.
REQ-020 start sampled in the same cycle that DONE returns to IDLE SHALL be ignored; start is accepted only in IDLE.
REQ-021 result SHALL hold its value after exdone until the next DONE.
REQ-022 Operand or mulctl changes after the latch edge SHALL NOT affect the operation in flight.
REQ-023 All arithmetic SHALL be modulo 2^(2*XLEN); the most-negative operand SHALL be handled by the magnitude path without overflow.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force: state IDLE, busy=0, exdone=0, result=0, count=0, accumulator=0.
REQ-025 Reset mid-operation SHALL abort the operation with no exdone pulse; the first start after release SHALL behave normally.

Configuration
REQ-026 Macro MUL_UNIT_ZERO_SKIP_EN defined: a latched operand equal to zero SHALL move IDLE->DONE directly, with result=0 and exdone 2 cycles after the start edge.
REQ-027 Macro MUL_UNIT_ZERO_SKIP_EN undefined: every operation SHALL take the full latency of REQ-017, zero operands included.

Structure
REQ-028 Package riscv_pkg SHALL hold the mulctl encodings (MULCTL_MUL, MULCTL_MULH, MULCTL_MULHSU, MULCTL_MULHU) and the mul_unit state encoding; the controller SHALL import the same constants.
REQ-029 SHALL be one module with no sub-modules; sign handling, counter and accumulator are inline.

Verification
REQ-030 MUL, rs1=7, rs2=6, one start pulse -> result=0x0000002A, exdone high once at cycle 33, busy low at cycle 34.
REQ-031 MULH, rs1=rs2=0xFFFFFFFF -> result=0x00000000; MULHU with the same operands -> 0xFFFFFFFE.
REQ-032 MULHSU, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> result=0xFFFFFFFF; MUL, rs1=0x80000000, rs2=2 -> 0x00000000.
REQ-033 start held high for 40 cycles with operands changed at cycle 5 -> exactly one exdone at cycle 33, using the cycle-0 operands.
REQ-034 rst_n pulsed low at cycle 10 of an operation -> busy=0 immediately, no exdone; a following MUL 3*5 -> 0x0000000F at latency 33.
REQ-035 MUL_UNIT_ZERO_SKIP_EN defined, rs1=0, rs2=0x1234 -> result=0 with exdone at cycle 2; macro undefined -> cycle 33.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multiply unit: mulctl operation select and FSM states.
package riscv_pkg;

  localparam logic [1:0] MULCTL_MUL    = 2'b00;
  localparam logic [1:0] MULCTL_MULH   = 2'b01;
  localparam logic [1:0] MULCTL_MULHSU = 2'b10;
  localparam logic [1:0] MULCTL_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier (RV32M MUL/MULH/MULHSU/MULHU), one step per clock.
// Optional MUL_UNIT_ZERO_SKIP_EN: a zero operand short-circuits to DONE.
module mul_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      mulctl,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            exdone,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  mul_state_e        state_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CW-1:0]     count_q;
  logic [1:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   result_q;
  logic              exdone_q;

  logic              rs1_neg_d;
  logic              rs2_neg_d;
  logic [XLEN-1:0]   mag1_d;
  logic [XLEN-1:0]   mag2_d;
  logic [XLEN:0]     sum_d;
  logic [2*XLEN-1:0] acc_d;
  logic [2*XLEN-1:0] product_d;
  logic              skip_d;

  // Operands are converted to magnitudes at latch time; the sign is re-applied in DONE.
  always_comb begin
    rs1_neg_d = rs1[XLEN-1] && ((mulctl == MULCTL_MULH) || (mulctl == MULCTL_MULHSU));
    rs2_neg_d = rs2[XLEN-1] && (mulctl == MULCTL_MULH);
    mag1_d    = rs1_neg_d ? (~rs1 + 1'b1) : rs1;
    mag2_d    = rs2_neg_d ? (~rs2 + 1'b1) : rs2;
  end

  // Low half of acc holds the remaining multiplier bits; the carry of the upper add shifts in.
  always_comb begin
    sum_d     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    acc_d     = {sum_d, acc_q[XLEN-1:1]};
    product_d = neg_q ? (~acc_q + 1'b1) : acc_q;
  end

`ifdef MUL_UNIT_ZERO_SKIP_EN
  assign skip_d = (count_q == '0) && ((mcand_q == '0) || (acc_q[XLEN-1:0] == '0));
`else
  assign skip_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      op_q     <= MULCTL_MUL;
      neg_q    <= 1'b0;
      result_q <= '0;
      exdone_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          exdone_q <= 1'b0;
          if (start) begin
            mcand_q <= mag1_d;
            acc_q   <= {{XLEN{1'b0}}, mag2_d};
            op_q    <= mulctl;
            neg_q   <= rs1_neg_d ^ rs2_neg_d;
            count_q <= '0;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (skip_d) begin
            acc_q   <= '0;
            neg_q   <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            acc_q   <= acc_d;
            count_q <= count_q + 1'b1;
            if (count_q == CW'(XLEN - 1)) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          result_q <= (op_q == MULCTL_MUL) ? product_d[XLEN-1:0] : product_d[2*XLEN-1:XLEN];
          exdone_q <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign exdone = exdone_q;
  assign result = result_q;

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit: products, latency, start handling, reset abort.
module tb_mul_unit;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mulctl;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        exdone;
  logic [31:0] result;

  int checks;
  int errors;
  int zero_lat;

  mul_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mulctl (mulctl),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .exdone (exdone),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One operation: start sampled at edge 0, observe cycles 1..40 (sampled 1 unit after each edge).
  task automatic run_op(input string tag, input logic [1:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int first_cyc;
    int n_done;
    first_cyc = -1;
    n_done    = 0;
    @(negedge clk);
    mulctl = ctl; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rs1 = 32'hDEAD_BEEF; rs2 = 32'h0BAD_F00D; mulctl = ~ctl;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) check({tag, "_busy_c1"}, {31'd0, busy}, 32'd1);
      if (exdone) begin
        n_done++;
        if (first_cyc < 0) first_cyc = i;
      end
      if (i == exp_lat + 1) check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    end
    check({tag, "_result"}, result, exp);
    check({tag, "_lat"}, first_cyc, exp_lat);
    check({tag, "_ndone"}, n_done, 32'd1);
  endtask

  initial begin
    int n_done;
    int first_cyc;
    checks = 0;
    errors = 0;
`ifdef MUL_UNIT_ZERO_SKIP_EN
    zero_lat = 2;
`else
    zero_lat = 33;
`endif
    rst_n = 1'b0; start = 1'b0; mulctl = MULCTL_MUL; rs1 = '0; rs2 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_exdone", {31'd0, exdone}, 32'd0);
    check("rst_result", result, 32'd0);
    rst_n = 1'b1;

    run_op("mul_7x6",      MULCTL_MUL,    32'd7,          32'd6,          32'h0000_002A, 33);
    repeat (5) @(posedge clk);
    #1 check("result_hold", result, 32'h0000_002A);
    run_op("mulh_m1xm1",   MULCTL_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 33);
    run_op("mulhu_m1xm1",  MULCTL_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33);
    run_op("mulhsu_m1xm1", MULCTL_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 33);
    run_op("mul_min_x2",   MULCTL_MUL,    32'h8000_0000,  32'd2,          32'h0000_0000, 33);
    run_op("mulh_minxmin", MULCTL_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 33);
    run_op("mulhsu_min_x2",MULCTL_MULHSU, 32'h8000_0000,  32'd2,          32'hFFFF_FFFF, 33);
    run_op("mul_m7x6",     MULCTL_MUL,    32'hFFFF_FFF9,  32'd6,          32'hFFFF_FFD6, 33);
    run_op("mulh_m7x6",    MULCTL_MULH,   32'hFFFF_FFF9,  32'd6,          32'hFFFF_FFFF, 33);
    run_op("mulhu_m1x2",   MULCTL_MULHU,  32'hFFFF_FFFF,  32'd2,          32'h0000_0001, 33);
    run_op("mul_zero",     MULCTL_MUL,    32'd0,          32'h0000_1234,  32'h0000_0000, zero_lat);

    // start held for 40 cycles, operands changed at cycle 5: one result from cycle-0 operands.
    first_cyc = -1;
    n_done    = 0;
    @(negedge clk);
    mulctl = MULCTL_MUL; rs1 = 32'd7; rs2 = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 5) begin rs1 = 32'd100; rs2 = 32'd100; end
      if (i == 39) start = 1'b0;
      if (exdone) begin
        n_done++;
        if (first_cyc < 0) first_cyc = i;
      end
    end
    check("hold_result", result, 32'h0000_002A);
    check("hold_lat", first_cyc, 32'd33);
    check("hold_ndone", n_done, 32'd1);

    // Reset aborts the operation relaunched by the held start, then reset mid-op at cycle 10.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mulctl = MULCTL_MUL; rs1 = 32'h1234_5678; rs2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_exdone", {31'd0, exdone}, 32'd0);
    check("abort_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (exdone) n_done++;
    end
    check("abort_no_done", n_done, 32'd0);
    run_op("mul_3x5", MULCTL_MUL, 32'd3, 32'd5, 32'h0000_000F, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
